product_bcd_conv: RTL



---
 rtl/product_pkg.sv | 11 +
 rtl/bcd_add3_digit.sv | 11 +
 rtl/product_bcd_conv.sv | 103 ++++++++++
 3 files changed

// File: rtl/product_pkg.sv
// product_pkg: shared widths, thresholds and FSM encoding for the product BCD converter.
package product_pkg;
  localparam int W_PRODUCT = 8;
  localparam int N_BCD_DIGITS = 3;
  localparam logic [3:0] BCD_ADD3_THRESH = 4'd5;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;
endpackage

// File: rtl/bcd_add3_digit.sv
// bcd_add3_digit: double-dabble digit correction, adds 3 to a BCD digit >= 5.
// Ports: digit_i  raw 4-bit BCD digit
//        digit_o  corrected digit, ready to be shifted left
module bcd_add3_digit
  import product_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);
  assign digit_o = digit_i >= BCD_ADD3_THRESH ? digit_i + 4'd3 : digit_i;
endmodule

// File: rtl/product_bcd_conv.sv
// product_bcd_conv: sequential shift-and-add-3 binary-to-BCD converter, one shift per clock.
// Ports: clk, rst_n (async, active-low)
//        in_valid/in_ready/bin_in     input handshake, accepted only in IDLE
//        out_valid/out_ready/bcd_out  result handshake, bcd_out = {hundreds, tens, ones}
//        busy                         high while shifting
//        blank_n                      leading-zero blanking mask (only with PRODUCT_BCD_LZB_EN)
// Optional feature macro: PRODUCT_BCD_LZB_EN
module product_bcd_conv
  import product_pkg::*;
#(
  parameter int W_IN     = W_PRODUCT,
  parameter int N_DIGITS = N_BCD_DIGITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [W_IN-1:0]       bin_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*N_DIGITS-1:0] bcd_out,
  output logic                  busy
`ifdef PRODUCT_BCD_LZB_EN
  ,
  output logic [N_DIGITS-1:0]   blank_n
`endif
);
  localparam int CW = W_IN > 1 ? $clog2(W_IN) : 1;
  localparam int BW = 4 * N_DIGITS;
  localparam int SW = BW + W_IN;
  if (10 ** N_DIGITS <= 2 ** W_IN - 1) begin : g_bad_cfg
    $error("N_DIGITS too small to hold 2^W_IN-1");
  end
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] sr_q, sr_d, sr_sh;
  logic [BW-1:0] adj, bcd_q, bcd_d;
  logic          last;
  for (genvar d = 0; d < N_DIGITS; d++) begin : g_add3
    bcd_add3_digit u_add3 (
      .digit_i(sr_q[W_IN+4*d +: 4]),
      .digit_o(adj[4*d +: 4])
    );
  end
  // Correct every digit first, then shift the whole {BCD, binary} register.
  assign sr_sh = {adj, sr_q[W_IN-1:0]} << 1;
  assign last  = cnt_q == CW'(W_IN - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      bcd_q   <= bcd_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    bcd_d   = bcd_q;
    case (state_q)
      IDLE: if (in_valid) begin
        state_d = SHIFT;
        cnt_d   = '0;
        sr_d    = SW'(bin_in);
      end
      SHIFT: begin
        sr_d  = sr_sh;
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          state_d = DONE;
          bcd_d   = sr_sh[SW-1:W_IN];
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    in_ready  = state_q == IDLE;
    busy      = state_q == SHIFT;
    out_valid = state_q == DONE;
  end
  assign bcd_out = bcd_q;
`ifdef PRODUCT_BCD_LZB_EN
  logic [N_DIGITS-1:0] blank_q, blank_d;
  // Digit k stays lit if it or any higher digit is nonzero; ones always lit.
  for (genvar k = 0; k < N_DIGITS; k++) begin : g_blank
    assign blank_d[k] = (k == 0) | (|bcd_d[BW-1:4*k]);
  end
  // bcd_d only moves on the DONE-entry edge, so this tracks bcd_out exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) blank_q <= N_DIGITS'(1);
    else blank_q <= blank_d;
  end
  assign blank_n = blank_q;
`endif
endmodule
